// File: rtl/tx_serializer_pkg.sv
// Shared types and line levels for the transmit serializer.
package tx_serializer_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/tx_fifo.sv
// Synchronous word FIFO with registered level and async reset.
module tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wr_data,
   output logic [WIDTH-1:0]       rd_data,
   output logic [$clog2(DEPTH):0] level,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Storage needs no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (level == (AW+1)'(DEPTH));
   assign empty   = (level == '0);

endmodule

// File: rtl/tx_serializer.sv
// Framed serial transmitter: start bit, DATA_W data bits, stop bit,
// paced by an external shift strobe and fed from a word FIFO.
module tx_serializer
   import tx_serializer_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter bit MSB_FIRST  = 1'b0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [DATA_W-1:0]           in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        shift,
   output logic                        serial_data,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        underrun
);

   localparam int CW = $clog2(DATA_W);
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   tx_state_t         state;
   tx_state_t         state_nx;
   logic [DATA_W-1:0] fifo_data;
   logic [DATA_W-1:0] sreg;
   logic [DATA_W-1:0] sreg_nx;
   logic [DATA_W-1:0] sreg_sh;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     cnt_nx;
   logic              head;
   logic              line_nx;
   logic              ur_nx;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;

   assign in_ready = !full;
   assign push     = in_valid && in_ready;
   assign busy     = (state != IDLE) || !empty;

   tx_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (pop),
      .wr_data (in_data),
      .rd_data (fifo_data),
      .level   (fifo_level),
      .full    (full),
      .empty   (empty)
   );

   // The outgoing bit always sits at one end of the shift register.
   assign head    = MSB_FIRST ? sreg[DATA_W-1] : sreg[0];
   assign sreg_sh = MSB_FIRST ? {sreg[DATA_W-2:0], 1'b0}
                              : {1'b0, sreg[DATA_W-1:1]};

   always_comb begin
      state_nx = state;
      sreg_nx  = sreg;
      cnt_nx   = cnt;
      line_nx  = serial_data;
      ur_nx    = 1'b0;
      pop      = 1'b0;
      if (shift) begin
         unique case (state)
            IDLE: begin
               line_nx = IDLE_LEVEL;
               if (!empty) begin
                  pop      = 1'b1;
                  sreg_nx  = fifo_data;
                  line_nx  = START_BIT;
                  state_nx = START;
               end
            end
            START: begin
               line_nx  = head;
               sreg_nx  = sreg_sh;
               cnt_nx   = '0;
               state_nx = DATA;
            end
            DATA: begin
               if (cnt == LAST) begin
                  line_nx  = STOP_BIT;
                  state_nx = STOP;
               end else begin
                  line_nx = head;
                  sreg_nx = sreg_sh;
                  cnt_nx  = cnt + 1'b1;
               end
            end
            STOP: begin
               if (!empty) begin
                  pop      = 1'b1;
                  sreg_nx  = fifo_data;
                  line_nx  = START_BIT;
                  state_nx = START;
               end else begin
                  line_nx  = IDLE_LEVEL;
                  ur_nx    = 1'b1;
                  state_nx = IDLE;
               end
            end
            default: begin
               line_nx  = IDLE_LEVEL;
               state_nx = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         sreg        <= '0;
         cnt         <= '0;
         serial_data <= IDLE_LEVEL;
         underrun    <= 1'b0;
      end else begin
         state       <= state_nx;
         sreg        <= sreg_nx;
         cnt         <= cnt_nx;
         serial_data <= line_nx;
         underrun    <= ur_nx;
      end
   end

endmodule

// File: doc/tx_serializer.md
# tx_serializer

Parametrised transmit serializer for the transceiver datapath. Accepts parallel words over a valid/ready handshake into an internal FIFO and shifts each word out as a framed serial stream: start bit, DATA_W data bits, stop bit. Bit-time pacing comes from an external `shift` strobe. Frames go back-to-back while words are buffered, and the block reports underrun when the stream goes dry.

## Interface
- `DATA_W`, default 8: data bits per frame; legal range 2..32.
- `FIFO_DEPTH`, default 4: buffered words; a power of 2, ≥2.
- `MSB_FIRST`, default 0: 0 sends data LSB first, 1 sends MSB first.

- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_data` input DATA_W: word to transmit.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: FIFO can accept a word.
- `shift` input 1: bit-time enable; one line-bit advance per cycle where it is high.
- `serial_data` output 1: registered serial line; idles high.
- `busy` output 1: FSM not IDLE, or FIFO not empty.
- `fifo_level` output $clog2(FIFO_DEPTH)+1: current number of buffered words.
- `underrun` output 1: single-cycle pulse when a frame completes and the FIFO is empty.

## Operation
- **Push:** occurs when `in_valid && in_ready`.
  - `in_ready` = (`fifo_level` < FIFO_DEPTH), decoded from registered level.
  - There is no combinational path from `in_valid` to `in_ready`.
- **Pop:** taken only by the FSM, only on a `shift` cycle, and only when the registered level is >0.
  - No bypass: a word pushed in cycle N is poppable from cycle N+1.
  - A simultaneous push and pop leaves the level unchanged.
  - When full, `in_ready`=0, so push cannot coincide with full. When empty, pop cannot occur.
- **FSM states:** IDLE, START, DATA, STOP. The FSM advances only on cycles with `shift`=1 and holds otherwise.
  - IDLE: on shift with FIFO non-empty, pop the word into the shift register, set `serial_data`←0, go to START. With FIFO empty, stay in IDLE with `serial_data`=1.
  - START: on shift, `serial_data`←first data bit, `bit_cnt`←0, go to DATA.
  - DATA: on shift with `bit_cnt`<DATA_W-1, output the next bit and increment. With `bit_cnt`=DATA_W-1, `serial_data`←1 and go to STOP.
  - STOP: on shift with FIFO non-empty, pop, `serial_data`←0, go to START (back-to-back, no idle bit). With FIFO empty, go to IDLE, keep `serial_data`=1, and pulse `underrun` for that cycle.
- **Bit order:**
  - MSB_FIRST=0: bit 0 first, shift register shifts right.
  - MSB_FIRST=1: bit DATA_W-1 first, shifts left.
  - Selection is at elaboration time.
- **Bit counter:** `bit_cnt` width is $clog2(DATA_W). It never wraps inside a frame.
- **Reset:**
  - On assertion (asynchronous): state IDLE, `serial_data`=1, FIFO emptied, `fifo_level`=0, `in_ready`=1, `busy`=0, `underrun`=0.
  - Reset mid-frame aborts the frame. The line returns high immediately, and buffered words are discarded.

## Timing
- All outputs are registered or decoded from registers only.
- Accept-to-start latency: a word accepted at edge N appears as a start bit no earlier than the first `shift` edge after N.
- Each line bit lasts from one shift edge to the next shift edge.
- A frame takes exactly DATA_W+2 shift cycles.
- Back-to-back frames have no idle gap while the FIFO is non-empty.
- `underrun` is high for exactly one clk cycle, coincident with the STOP→IDLE transition.
- `busy` falls in the cycle after STOP→IDLE, provided the FIFO is empty.
- `shift` held continuously high is legal, giving 1 bit per clk.

## Structure
- **Package `tx_serializer_pkg`:**
  - `tx_state_t` enum (IDLE, START, DATA, STOP).
  - `START_BIT`=1'b0, `STOP_BIT`=1'b1, `IDLE_LEVEL`=1'b1.
- **Sub-module `tx_fifo`:** synchronous FIFO (WIDTH, DEPTH) with push/pop, level, full, empty, and asynchronous reset. The top holds only the FSM, shift register and counter.

## Test plan
- Reset, then no traffic: `serial_data`=1, `in_ready`=1, `busy`=0, `fifo_level`=0 for 20 cycles with `shift`=1.
- DATA_W=8, MSB_FIRST=0, push 0x01 once, `shift`=1 continuously: line shows 0,1,0,0,0,0,0,0,0,1. Then `underrun` pulses once and the line stays 1.
- Same with MSB_FIRST=1 and 0x01: line shows 0,0,0,0,0,0,0,0,1,1.
- Push 0xA5 then 0x3C, `shift`=1 every 3rd cycle: two 10-bit frames with no idle bit between them, each bit held 3 cycles, and a single `underrun` after the second frame.
- Push 5 words into FIFO_DEPTH=4 with `shift`=0: `in_ready` drops after 4 words and `fifo_level`=4. Enable `shift`: `in_ready` reasserts after the first pop, and the 5th word is accepted.
- Assert `rst_n`=0 in the middle of a data bit: `serial_data`=1 and `fifo_level`=0 immediately. After release, no residual frame is emitted.
